// File: rtl/cubic_feeder.sv
// cubic_feeder: fetches four clamped taps and the t powers, sequences them into the cubic
// engine, and holds the engine result in a valid/ready output register.
module cubic_feeder #(
    parameter int AW = 14,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [7:0]    req_t,
    input  logic [SW-1:0] req_stride,
    input  logic [AW-1:0] req_lo,
    input  logic [AW-1:0] req_hi,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic [23:0]   eng_x,
    output logic [7:0]    eng_p,
    output logic [2:0]    eng_cnt,
    input  logic [7:0]    eng_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [7:0]    res_data
);
    typedef enum logic [2:0] {IDLE, X0, T1, T2, T3, T4, CAPT} state_t;
    state_t state;
    logic [AW-1:0] a0, a1, a2, am1_n, a1_n, a2_n;
    logic signed [AW+1:0] addr_s, str_s, lo_s, hi_s, dn, up1, up2;
    logic [15:0] sq, cu;
    logic [7:0] t2, t3;
    logic free, take;
    // two spare bits keep the tap arithmetic from wrapping before the clamp
    assign addr_s = (AW+2)'(req_addr);
    assign str_s = (AW+2)'(req_stride);
    assign lo_s = (AW+2)'(req_lo);
    assign hi_s = (AW+2)'(req_hi);
    assign dn = addr_s - str_s;
    assign up1 = addr_s + str_s;
    assign up2 = addr_s + (str_s <<< 1);
    assign am1_n = dn < lo_s ? req_lo : AW'(dn);
    assign a1_n = up1 > hi_s ? req_hi : AW'(up1);
    assign a2_n = up2 > hi_s ? req_hi : AW'(up2);
    assign sq = 16'(req_t) * 16'(req_t) + 16'd128;
    assign t2 = 8'(sq >> 8);
    assign cu = 16'(t2) * 16'(req_t) + 16'd128;
    assign t3 = 8'(cu >> 8);
    assign free = !res_valid || res_ready;
    assign req_ready = rst && state == IDLE && free;
    assign take = req_valid && req_ready;
    assign eng_p = state inside {T1, T2, T3, T4} ? mem_rdata : 8'd0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            res_valid <= 1'b0;
            res_data <= 8'd0;
            mem_rd_en <= 1'b0;
            mem_addr <= '0;
            eng_x <= 24'd0;
            eng_cnt <= 3'd0;
        end else begin
            if (res_valid && res_ready)
                res_valid <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    state <= X0;
                    eng_x <= {req_t, t2, t3};
                    eng_cnt <= 3'd0;
                    mem_rd_en <= 1'b1;
                    mem_addr <= am1_n;
                    a0 <= req_addr;
                    a1 <= a1_n;
                    a2 <= a2_n;
                end
                X0: begin
                    state <= T1;
                    eng_cnt <= 3'd1;
                    mem_addr <= a0;
                end
                T1: begin
                    state <= T2;
                    eng_cnt <= 3'd2;
                    mem_addr <= a1;
                end
                T2: begin
                    state <= T3;
                    eng_cnt <= 3'd3;
                    mem_addr <= a2;
                end
                T3: begin
                    state <= T4;
                    eng_cnt <= 3'd4;
                    mem_rd_en <= 1'b0;
                end
                T4: begin
                    state <= CAPT;
                    eng_cnt <= 3'd0;
                end
                CAPT: if (free) begin
                    state <= IDLE;
                    res_data <= eng_out;
                    res_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cubic_feeder.sv
// tb_cubic_feeder: random jobs against a reference built from the tap/power rules,
// with a Catmull-Rom engine model and a synchronous SRAM model.
module tb_cubic_feeder;
    localparam int AW = 14;
    localparam int SW = 8;
    logic clk = 0, rst = 0, req_valid = 0, res_ready = 0;
    logic [AW-1:0] req_addr = '0, req_lo = '0, req_hi = '0;
    logic [7:0] req_t = '0;
    logic [SW-1:0] req_stride = 1;
    logic req_ready, mem_rd_en, res_valid;
    logic [AW-1:0] mem_addr;
    logic [7:0] mem_rdata = '0, eng_p, eng_out, res_data;
    logic [23:0] eng_x, ex;
    logic [2:0] eng_cnt;
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] ep [4];
    int checks = 0, errors = 0;

    cubic_feeder #(.AW(AW), .SW(SW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_t(req_t), .req_stride(req_stride), .req_lo(req_lo),
        .req_hi(req_hi), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .eng_x(eng_x), .eng_p(eng_p), .eng_cnt(eng_cnt), .eng_out(eng_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cr(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d, logic [23:0] x);
        int pa, pb, pc, pd, t, q, u, n;
        pa = a; pb = b; pc = c; pd = d;
        t = x[23:16]; q = x[15:8]; u = x[7:0];
        n = 512 * pb + (pc - pa) * t + (2 * pa - 5 * pb + 4 * pc - pd) * q
            + (-pa + 3 * pb - 3 * pc + pd) * u + 256;
        n = n >>> 9;
        return n < 0 ? 8'd0 : (n > 255 ? 8'd255 : 8'(n));
    endfunction

    function automatic logic [23:0] pw(int t);
        int q, u;
        q = (t * t + 128) / 256;
        u = (q * t + 128) / 256;
        return {8'(t), 8'(q), 8'(u)};
    endfunction

    function automatic int tap(int a, int s, int lo, int hi, int k);
        int v;
        v = a + k * s;
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction

    always @(posedge clk) begin
        if (eng_cnt >= 3'd1 && eng_cnt <= 3'd4) ep[int'(eng_cnt) - 1] <= eng_p;
        if (eng_cnt == 3'd1) ex <= eng_x;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end
    always_comb eng_out = cr(ep[0], ep[1], ep[2], ep[3], ex);

    task automatic run_job(input int a, input int t, input int s, input int lo, input int hi,
                           input logic rdy, output logic [7:0] r);
        int tp[4];
        int n;
        logic [23:0] x;
        logic [7:0] pe;
        for (int k = 0; k < 4; k++) tp[k] = tap(a, s, lo, hi, k - 1);
        x = pw(t);
        r = cr(mem[tp[0]], mem[tp[1]], mem[tp[2]], mem[tp[3]], x);
        res_ready = rdy;
        req_valid = 1; req_addr = AW'(a); req_t = 8'(t); req_stride = SW'(s);
        req_lo = AW'(lo); req_hi = AW'(hi);
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL accept: req_ready=%b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 0;
        for (int k = 0; k < 6; k++) begin
            pe = (k >= 1 && k <= 4) ? mem[tp[k == 0 ? 0 : k - 1]] : 8'd0;
            checks++; if (eng_cnt !== 3'(k < 5 ? k : 0)) begin errors++; $display("FAIL eng_cnt[%0d]: got %0d want %0d", k, eng_cnt, k < 5 ? k : 0); end
            checks++; if (mem_rd_en !== (k < 4)) begin errors++; $display("FAIL mem_rd_en[%0d]: got %b", k, mem_rd_en); end
            if (k < 4) begin
                checks++; if (mem_addr !== AW'(tp[k])) begin errors++; $display("FAIL mem_addr[%0d]: got %0d want %0d", k, mem_addr, tp[k]); end
            end
            checks++; if (eng_p !== pe) begin errors++; $display("FAIL eng_p[%0d]: got %0d want %0d", k, eng_p, pe); end
            checks++; if (eng_x !== x) begin errors++; $display("FAIL eng_x[%0d]: got %h want %h", k, eng_x, x); end
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL res_early[%0d]: res_valid=%b want 0", k, res_valid); end
            @(posedge clk); #1;
        end
        checks++; if (res_valid !== 1'b1 || res_data !== r) begin errors++; $display("FAIL result: valid=%b data=%0d want 1/%0d", res_valid, res_data, r); end
    endtask

    task automatic test_reset();
        rst = 0; req_valid = 1; res_ready = 0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if ({res_valid, req_ready, mem_rd_en, eng_cnt, res_data, mem_addr, eng_x} !== '0) begin
                errors++; $display("FAIL reset: v=%b rdy=%b rd=%b cnt=%0d d=%0d a=%0d x=%h want all 0",
                    res_valid, req_ready, mem_rd_en, eng_cnt, res_data, mem_addr, eng_x);
            end
        end
        req_valid = 0; rst = 1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release: req_ready=%b want 1", req_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] r;
        mem[99] = 10; mem[100] = 20; mem[101] = 30; mem[102] = 40;
        run_job(100, 0, 1, 0, 199, 1, r);
        checks++; if (res_data !== 8'd20) begin errors++; $display("FAIL basic: res_data=%0d want 20", res_data); end
    endtask

    task automatic test_powers();
        logic [7:0] r;
        run_job(500, 128, 3, 0, 9999, 1, r);
        checks++; if (eng_x !== 24'h804020) begin errors++; $display("FAIL pow128: eng_x=%h want 804020", eng_x); end
        run_job(500, 255, 3, 0, 9999, 1, r);
        checks++; if (eng_x !== 24'hFFFEFD) begin errors++; $display("FAIL pow255: eng_x=%h want fffefd", eng_x); end
    endtask

    task automatic test_clamp();
        logic [7:0] r;
        run_job(0, $urandom_range(0, 255), 1, 0, 99, 1, r);
        run_job(99, $urandom_range(0, 255), 1, 0, 99, 1, r);
        run_job(50, $urandom_range(0, 255), 100, 0, 9999, 1, r);
        run_job(16380, $urandom_range(0, 255), 255, 16000, 16383, 1, r);
    endtask

    task automatic test_random();
        logic [7:0] r;
        int lo, hi;
        for (int i = 0; i < 25; i++) begin
            lo = $urandom_range(0, 8000);
            hi = lo + $urandom_range(0, 8000);
            run_job($urandom_range(lo, hi), $urandom_range(0, 255), $urandom_range(1, 255), lo, hi, 1, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        run_job(1234, 77, 9, 1000, 2000, 1, r);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b: req_ready=%b want 1 after capture", req_ready); end
        run_job(1240, 200, 20, 1000, 2000, 1, r);
    endtask

    task automatic test_backpressure();
        logic [7:0] r1, r2;
        @(posedge clk); #1;
        run_job(3000, 90, 40, 2950, 3050, 0, r1);
        req_valid = 1; req_addr = 14'd4000; req_t = 8'd33; req_stride = 8'd5;
        repeat (5) begin
            @(posedge clk); #1;
            checks++; if (req_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== r1 || mem_rd_en !== 1'b0) begin
                errors++; $display("FAIL stall: rdy=%b v=%b d=%0d rd=%b want 0/1/%0d/0", req_ready, res_valid, res_data, mem_rd_en, r1);
            end
        end
        run_job(4000, 33, 5, 3990, 4100, 1, r2);
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        res_ready = 1; req_valid = 1; req_addr = 14'd700; req_t = 8'd10; req_stride = 8'd2;
        req_lo = 14'd0; req_hi = 14'd9999;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (eng_cnt !== 3'd2) begin errors++; $display("FAIL mid_state: eng_cnt=%0d want 2", eng_cnt); end
        rst = 0;
        @(posedge clk); #1;
        checks++; if ({res_valid, mem_rd_en, eng_cnt, req_ready} !== '0) begin
            errors++; $display("FAIL mid_reset: v=%b rd=%b cnt=%0d rdy=%b want 0", res_valid, mem_rd_en, eng_cnt, req_ready);
        end
        rst = 1;
        repeat (8) begin
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b0 || mem_rd_en !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL abandoned: v=%b rd=%b rdy=%b want 0/0/1", res_valid, mem_rd_en, req_ready);
            end
        end
        run_job(800, 150, 7, 0, 9999, 1, r);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_powers();
        test_clamp();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
